// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - receive-side data/status handshake bundle for uart_receiver
interface uart_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rxData;
  logic                  rxValid;
  logic                  rxReady;
  logic                  parityError;
  logic                  framingError;
  logic                  breakingError;
  logic                  overrunError;

  modport master (
    output rxData, rxValid, parityError, framingError, breakingError, overrunError,
    input  rxReady
  );

  modport slave (
    input  rxData, rxValid, parityError, framingError, breakingError, overrunError,
    output rxReady
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver with parity, framing, break and overrun status
module uart_receiver #(
  parameter int DATA_WIDTH   = 8,
  parameter int OVERSAMPLING = 16,
  parameter int SAMPLE_DIV   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic [3:0]      dataType,
  input  logic            parityEnable,
  input  logic            parityType,
  input  logic [1:0]      stopBits,
  uart_receiver_if.master rx_if
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TCK_W = $clog2(OVERSAMPLING);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(OVERSAMPLING - 1);
  // start bit is sampled on the (OVERSAMPLING/2)-th tick after the edge
  localparam logic [TCK_W-1:0] TCK_HALF = TCK_W'(OVERSAMPLING / 2 - 1);

  typedef enum logic [2:0] {IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [TCK_W-1:0]      tck_q, tck_d;
  logic [3:0]            nbits_q, nbits_d, bcnt_q, bcnt_d;
  logic                  pen_q, pen_d, pty_q, pty_d, two_q, two_d, scnt_q, scnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic                  par_q, par_d, zero_q, zero_d, fe_q, fe_d, brk_q, brk_d;
  logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  berr_q, berr_d, oerr_q, oerr_d;
  logic                  rx_s, tick, samp, done, fe_fin, zero_fin;

  // next-state, sampling and holding-register update logic
  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;
    rx_s     = sync2_q;
    prev_d   = rx_s;
    state_d  = state_q;
    nbits_d  = nbits_q;
    bcnt_d   = bcnt_q;
    pen_d    = pen_q;
    pty_d    = pty_q;
    two_d    = two_q;
    scnt_d   = scnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    zero_d   = zero_q;
    fe_d     = fe_q;
    brk_d    = brk_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    berr_d   = berr_q;
    oerr_d   = oerr_q;
    done     = 1'b0;
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + 1'b1;
    tck_d    = tck_q;
    if (tick) tck_d = (tck_q == TCK_LAST) ? '0 : tck_q + 1'b1;
    samp     = tick && (tck_q == ((state_q == STARTBIT) ? TCK_HALF : TCK_LAST));
    fe_fin   = fe_q | ~rx_s;
    // only the first stop bit takes part in break detection
    zero_fin = scnt_q ? zero_q : (zero_q & ~rx_s);

    case (state_q)
      IDLE: begin
        if (brk_q) begin
          if (tick && rx_s) brk_d = 1'b0;
        end else if (prev_q && !rx_s) begin
          state_d = STARTBIT;
          div_d   = '0;
          tck_d   = '0;
          nbits_d = (dataType >= 4'd5 && dataType <= 4'd8) ? dataType : 4'd8;
          pen_d   = parityEnable;
          pty_d   = parityType;
          two_d   = (stopBits == 2'd2);
          bcnt_d  = '0;
          scnt_d  = 1'b0;
          shift_d = '0;
          par_d   = 1'b0;
          zero_d  = 1'b1;
          fe_d    = 1'b0;
        end
      end
      STARTBIT: begin
        if (samp) begin
          tck_d   = '0;
          state_d = rx_s ? IDLE : DATABITS;
        end
      end
      DATABITS: begin
        if (samp) begin
          shift_d = shift_q | (DATA_WIDTH'(rx_s) << bcnt_q);
          par_d   = par_q ^ rx_s;
          zero_d  = zero_q & ~rx_s;
          bcnt_d  = bcnt_q + 4'd1;
          if (bcnt_q == nbits_q - 4'd1) state_d = pen_q ? PARITYBIT : STOPBIT;
        end
      end
      PARITYBIT: begin
        if (samp) begin
          par_d   = par_q ^ rx_s;
          zero_d  = zero_q & ~rx_s;
          state_d = STOPBIT;
        end
      end
      STOPBIT: begin
        if (samp) begin
          fe_d   = fe_fin;
          zero_d = zero_fin;
          scnt_d = 1'b1;
          if (scnt_q || !two_q) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = valid_q & ~rx_if.rxReady;
    // a completing frame always wins over a same-cycle acknowledge
    if (done) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      perr_d  = pen_q & (par_q != pty_q);
      ferr_d  = fe_fin;
      berr_d  = zero_fin;
      oerr_d  = valid_q & ~rx_if.rxReady;
      brk_d   = zero_fin;
    end
  end

  // state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      div_q   <= '0;
      tck_q   <= '0;
      nbits_q <= 4'd8;
      bcnt_q  <= '0;
      pen_q   <= 1'b0;
      pty_q   <= 1'b0;
      two_q   <= 1'b0;
      scnt_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      zero_q  <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      berr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      nbits_q <= nbits_d;
      bcnt_q  <= bcnt_d;
      pen_q   <= pen_d;
      pty_q   <= pty_d;
      two_q   <= two_d;
      scnt_q  <= scnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      zero_q  <= zero_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      berr_q  <= berr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign rx_if.rxData        = data_q;
  assign rx_if.rxValid       = valid_q;
  assign rx_if.parityError   = perr_q;
  assign rx_if.framingError  = ferr_q;
  assign rx_if.breakingError = berr_q;
  assign rx_if.overrunError  = oerr_q;
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the maximum data bits per frame and the width of rxData.
REQ-002 Parameter OVERSAMPLING, default 16, SHALL set oversample ticks per bit; legal values are 13 and 16.
REQ-003 Parameter SAMPLE_DIV, default 1, SHALL set clk cycles per oversample tick, so one bit period = OVERSAMPLING*SAMPLE_DIV clocks.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 rx  input  1  SHALL be the asynchronous serial line; idle high.
REQ-007 dataType  input  4  SHALL select data bits per frame, 5..8; other values are treated as 8.
REQ-008 parityEnable  input  1  SHALL select whether a parity bit follows the data bits (1 = present).
REQ-009 parityType  input  1  SHALL select parity: 0 = even, 1 = odd.
REQ-010 stopBits  input  2  SHALL select stop bits: 1 or 2; any other value is treated as 1.
REQ-011 rxReady  input  1  SHALL be the consumer acknowledge.
REQ-012 rxData  output  DATA_WIDTH  SHALL carry received data, zero-extended above dataType.
REQ-013 rxValid  output  1  SHALL flag rxData and the error flags as valid.
REQ-014 parityError, framingError, breakingError, overrunError  output  1 each  SHALL be per-frame status, valid with rxValid.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-016 An internal divider SHALL emit one tick every SAMPLE_DIV clocks, plus a tick counter 0..OVERSAMPLING-1; both restart on start-edge detection.
REQ-017 FSM states SHALL be IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT.
REQ-018 IDLE -> STARTBIT SHALL occur on a synchronized high-to-low transition; dataType, parityEnable, parityType and stopBits SHALL be latched at this point, and mid-frame changes SHALL be ignored.
REQ-019 In STARTBIT, rx SHALL be sampled at tick OVERSAMPLING/2; low -> DATABITS, high -> IDLE (false start, no rxValid and no flags).
REQ-020 Each later bit SHALL be sampled exactly OVERSAMPLING ticks after the previous sample point.
REQ-021 Data SHALL be received LSB first; a bit counter SHALL advance DATABITS -> PARITYBIT after dataType bits when parityEnable=1, else -> STOPBIT.
REQ-022 parityError SHALL be 1 when (XOR of data bits XOR parity bit) != parityType; it SHALL be 0 when parity is disabled.
REQ-023 STOPBIT SHALL sample stopBits stop bits; framingError SHALL be 1 if any sampled stop bit is 0.
REQ-024 breakingError SHALL be 1 when all data bits, the parity bit (if present) and the first stop bit are 0; framingError is also 1 in this case.
REQ-025 After a break, the FSM SHALL stay in IDLE and SHALL NOT detect a new start until rx has been high for at least one tick.
REQ-026 On the clock after the final stop sample, the FSM SHALL load rxData and the flags into holding registers, set rxValid=1 and return to IDLE; at least 2 stop bits are never required to re-arm.
REQ-027 rxValid SHALL stay 1 until a cycle with rxValid && rxReady, then clear on the next edge.
REQ-028 If a frame completes while rxValid=1 and rxReady=0, the new data and flags SHALL overwrite the holding registers, overrunError SHALL be 1 and rxValid SHALL stay 1.
REQ-029 If a completion and rxReady coincide, the new frame SHALL win: rxValid stays 1, overrunError=0.
REQ-030 Latency: rxValid SHALL rise no later than (1 + dataType + parityEnable + stopBits - 0.5) bit periods + 4 clocks after the rx falling edge.

Reset
REQ-031 reset=0 SHALL at once force the FSM to IDLE, clear all counters, set the synchronizer flops to 1, and drive rxData=0, rxValid=0 and all error flags to 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; after release, the first new falling edge starts a fresh frame.

Verification (OVERSAMPLING=16, SAMPLE_DIV=1, bit = 16 clocks)
REQ-033 8N1, byte 0xA5, rxReady=1 -> rxData=0xA5, rxValid for 1 cycle, all flags 0.
REQ-034 7E1, data 0x41, wrong parity bit 1 -> rxData=0x41, parityError=1; same frame with parity 0 -> parityError=0.
REQ-035 8N2, 0x3C with second stop bit 0 -> framingError=1, breakingError=0; line held low for 12 bits -> breakingError=1, framingError=1, rxData=0x00.
REQ-036 rx low pulse of 5 clocks -> false start, no rxValid; a following valid frame 0x5A is received correctly.
REQ-037 Two back-to-back frames 0x11 then 0x22 with rxReady=0 -> rxData=0x22, overrunError=1, rxValid=1 held; rxReady=1 for one cycle -> rxValid=0 next cycle.
REQ-038 reset pulse during DATABITS of frame 0xFF -> outputs cleared, no rxValid; the next frame 0x0F is received with all flags 0.
